// File: rtl/secure_subsystem_isolate_pkg.sv
// Shared types for the per-port AXI isolation controller: FSM state encoding and counter sizing.
// Pure declarations; no logic, latency or backpressure of its own.
package secure_subsystem_isolate_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DRAIN    = 2'd1,
      ISOLATED = 2'd2,
      FORCED   = 2'd3
   } iso_state_e;

   // Width needed to hold 0..max_val inclusive, never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/secure_subsystem_isolate_port.sv
// One AXI port: outstanding-transaction tracking, drain/isolate FSM and sticky status flags.
// All outputs registered, valid the cycle after the inputs that cause them; block_o backpressures new AW/AR upstream.
module secure_subsystem_isolate_port
   import secure_subsystem_isolate_pkg::*;
#(
   parameter int MaxPending    = 8,
   parameter int TimeoutCycles = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic isolate_req_i,
   input  logic aw_hs_i,
   input  logic ar_hs_i,
   input  logic b_hs_i,
   input  logic r_last_hs_i,
   output logic block_o,
   output logic isolated_o,
   output logic timeout_o,
   output logic err_o
);

   localparam int CW = cnt_width(MaxPending);
   localparam int TW = cnt_width(TimeoutCycles);
   localparam logic [CW-1:0] CntMax  = CW'(MaxPending);
   localparam logic [TW-1:0] TmoLast = TW'(TimeoutCycles - 1);

   iso_state_e    state_q, state_d;
   logic [CW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   logic [CW-1:0] wr_step, rd_step;
   logic          wr_err, rd_err;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          drained, tmo_hit, proto_err;
   logic          block_q, isolated_q, timeout_q, err_q;
   logic          block_d, isolated_d, timeout_d, err_d;

   // Returns {error, next_count}; saturates at both ends and flags the attempt.
   function automatic logic [CW:0] step_cnt(input logic [CW-1:0] cnt,
                                            input logic          inc,
                                            input logic          dec);
      logic [CW:0] res;
      res = {1'b0, cnt};
      if (inc && !dec) begin
         if (cnt == CntMax) res[CW] = 1'b1;
         else               res[CW-1:0] = cnt + CW'(1);
      end else if (dec && !inc) begin
         if (cnt == '0) res[CW] = 1'b1;
         else           res[CW-1:0] = cnt - CW'(1);
      end
      return res;
   endfunction

   always_comb begin
      {wr_err, wr_step} = step_cnt(wr_cnt_q, aw_hs_i, b_hs_i);
      {rd_err, rd_step} = step_cnt(rd_cnt_q, ar_hs_i, r_last_hs_i);
      wr_cnt_d = wr_step;
      rd_cnt_d = rd_step;
      // Leaving FORCED discards whatever the stuck slave still owed us.
      if (state_q == FORCED && !isolate_req_i) begin
         wr_cnt_d = '0;
         rd_cnt_d = '0;
      end
      drained   = (wr_step == '0) && (rd_step == '0);
      tmo_hit   = (TimeoutCycles > 0) && (tmo_cnt_q == TmoLast);
      proto_err = wr_err || rd_err || ((state_q != RUN) && (aw_hs_i || ar_hs_i));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Drain completion is judged on this cycle's updated counts so isolation follows the last response directly.
   always_comb begin
      state_d   = state_q;
      tmo_cnt_d = '0;
      unique case (state_q)
         RUN: begin
            if (isolate_req_i) state_d = DRAIN;
         end
         DRAIN: begin
            if (!isolate_req_i) state_d = RUN;
            else if (drained)   state_d = ISOLATED;
            else if (tmo_hit)   state_d = FORCED;
            else                tmo_cnt_d = tmo_cnt_q + TW'(1);
         end
         ISOLATED, FORCED: begin
            if (!isolate_req_i) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      block_d    = (state_d != RUN) || (wr_cnt_d == CntMax) || (rd_cnt_d == CntMax);
      isolated_d = (state_d == ISOLATED) || (state_d == FORCED);
      timeout_d  = timeout_q || ((state_q == DRAIN) && (state_d == FORCED));
      err_d      = err_q || proto_err;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         tmo_cnt_q  <= '0;
         block_q    <= 1'b0;
         isolated_q <= 1'b0;
         timeout_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         block_q    <= block_d;
         isolated_q <= isolated_d;
         timeout_q  <= timeout_d;
         err_q      <= err_d;
      end
   end

   assign block_o    = block_q;
   assign isolated_o = isolated_q;
   assign timeout_o  = timeout_q;
   assign err_o      = err_q;

endmodule

// File: rtl/secure_subsystem_isolate_ctrl.sv
// Isolation controller for NumPorts independent AXI ports; each port drains, then isolates or times out.
// One-cycle registered outputs per port; block_o is the upstream backpressure gate for new AW/AR.
module secure_subsystem_isolate_ctrl
   import secure_subsystem_isolate_pkg::*;
#(
   parameter int NumPorts      = 2,
   parameter int MaxPending    = 8,
   parameter int TimeoutCycles = 1024
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NumPorts-1:0] isolate_req_i,
   input  logic [NumPorts-1:0] aw_hs_i,
   input  logic [NumPorts-1:0] ar_hs_i,
   input  logic [NumPorts-1:0] b_hs_i,
   input  logic [NumPorts-1:0] r_last_hs_i,
   output logic [NumPorts-1:0] block_o,
   output logic [NumPorts-1:0] isolated_o,
   output logic [NumPorts-1:0] timeout_o,
   output logic [NumPorts-1:0] err_o
);

   for (genvar p = 0; p < NumPorts; p++) begin : g_port
      secure_subsystem_isolate_port #(
         .MaxPending    (MaxPending),
         .TimeoutCycles (TimeoutCycles)
      ) u_port (
         .clk_i         (clk_i),
         .rst_i         (rst_i),
         .isolate_req_i (isolate_req_i[p]),
         .aw_hs_i       (aw_hs_i[p]),
         .ar_hs_i       (ar_hs_i[p]),
         .b_hs_i        (b_hs_i[p]),
         .r_last_hs_i   (r_last_hs_i[p]),
         .block_o       (block_o[p]),
         .isolated_o    (isolated_o[p]),
         .timeout_o     (timeout_o[p]),
         .err_o         (err_o[p])
      );
   end

endmodule

// File: tb/tb_secure_subsystem_isolate_ctrl.sv
// Table-driven bench: each row drives one cycle of inputs and states the outputs expected right after that edge.
// Expectations are queued when a row is driven and checked once the edge has produced the DUT's response.
module tb_secure_subsystem_isolate_ctrl;

   localparam int NP = 2;
   localparam int MP = 4;
   localparam int TO = 16;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [NP-1:0] isolate_req_i, aw_hs_i, ar_hs_i, b_hs_i, r_last_hs_i;
   logic [NP-1:0] block_o, isolated_o, timeout_o, err_o;

   always #5 clk_i = ~clk_i;

   secure_subsystem_isolate_ctrl #(
      .NumPorts      (NP),
      .MaxPending    (MP),
      .TimeoutCycles (TO)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .isolate_req_i (isolate_req_i),
      .aw_hs_i       (aw_hs_i),
      .ar_hs_i       (ar_hs_i),
      .b_hs_i        (b_hs_i),
      .r_last_hs_i   (r_last_hs_i),
      .block_o       (block_o),
      .isolated_o    (isolated_o),
      .timeout_o     (timeout_o),
      .err_o         (err_o)
   );

   typedef struct {
      logic       rst;
      logic [1:0] req, aw, ar, b, r;
      logic [1:0] blk, iso, tmo, err;
      string      tag;
   } vec_t;

   typedef struct {
      logic [1:0] blk, iso, tmo, err;
      string      tag;
      int         idx;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic add(input string t, input logic rs,
                      input logic [1:0] rq, input logic [1:0] aw, input logic [1:0] ar,
                      input logic [1:0] b,  input logic [1:0] r,
                      input logic [1:0] bk, input logic [1:0] is,
                      input logic [1:0] tm, input logic [1:0] er);
      vec_t v;
      v.rst = rs; v.req = rq; v.aw = aw; v.ar = ar; v.b = b; v.r = r;
      v.blk = bk; v.iso = is; v.tmo = tm; v.err = er; v.tag = t;
      tbl.push_back(v);
   endtask

   task automatic chk(input string t, input int idx, input string what,
                      input logic [1:0] got, input logic [1:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s row %0d %s: got %b want %b", t, idx, what, got, want);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      rst_i = 1'b1;
      isolate_req_i = '0; aw_hs_i = '0; ar_hs_i = '0; b_hs_i = '0; r_last_hs_i = '0;

      //        tag       rst req    aw     ar     b      r      blk    iso    tmo    err
      // Clean drain on port0: three writes, request, three B responses spaced out.
      add("drain", 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      for (int i = 0; i < 3; i++)
         add("drain", 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("drain", 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add("drain", 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add("drain", 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add("drain", 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add("drain", 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add("drain", 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
      add("drain", 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
      add("drain", 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01);
      add("drain", 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);

      // Timeout on port1: one read never answered; forced on drain cycle 16, counters cleared on exit.
      add("tmo", 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("tmo", 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("tmo", 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
      for (int i = 0; i < TO - 1; i++)
         add("tmo", 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
      add("tmo", 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00);
      add("tmo", 0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00);
      add("tmo", 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
      add("tmo", 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10);

      // Flow control on port0 writes: full blocks, one B unblocks, overflow saturates at MaxPending.
      add("flow", 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      for (int i = 0; i < MP - 1; i++)
         add("flow", 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("flow", 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add("flow", 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("flow", 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add("flow", 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
      add("flow", 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);

      // Simultaneous inc/dec on port1, underflow at zero, and same-cycle AR+R at zero on port0.
      add("simul", 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("simul", 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("simul", 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("simul", 0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("simul", 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("simul", 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
      for (int i = 0; i < MP; i++)
         add("simul", 0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("simul", 0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
      for (int i = 0; i < MP - 1; i++)
         add("simul", 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
      add("simul", 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10);
      add("simul", 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10);
      add("simul", 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11);

      // Port0 isolates while port1 reads keep flowing; port1 aborts a drain, then re-drains to a full timeout.
      add("indep", 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("indep", 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("indep", 0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add("indep", 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
      add("indep", 0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
      add("indep", 0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
      add("indep", 0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
      add("indep", 0, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00);
      add("indep", 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00);
      add("indep", 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00);
      add("indep", 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00);
      for (int i = 0; i < 3; i++)
         add("indep", 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00);
      add("indep", 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
      add("indep", 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00);
      for (int i = 0; i < TO - 1; i++)
         add("indep", 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00);
      add("indep", 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b10, 2'b00);

      // Reset while port1 is FORCED with a sticky error, then reset mid-DRAIN on port0.
      add("reset", 0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b10, 2'b10);
      add("reset", 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("reset", 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      for (int i = 0; i < MP - 1; i++)
         add("reset", 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("reset", 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
      add("reset", 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
      add("reset", 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add("reset", 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk_i);
         rst_i         = tbl[i].rst;
         isolate_req_i = tbl[i].req;
         aw_hs_i       = tbl[i].aw;
         ar_hs_i       = tbl[i].ar;
         b_hs_i        = tbl[i].b;
         r_last_hs_i   = tbl[i].r;
         e.blk = tbl[i].blk; e.iso = tbl[i].iso; e.tmo = tbl[i].tmo; e.err = tbl[i].err;
         e.tag = tbl[i].tag; e.idx = i;
         sb.push_back(e);
         @(posedge clk_i);
         #1;
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard row %0d: got empty queue want one entry", i);
         end else begin
            e = sb.pop_front();
            chk(e.tag, e.idx, "block_o",    block_o,    e.blk);
            chk(e.tag, e.idx, "isolated_o", isolated_o, e.iso);
            chk(e.tag, e.idx, "timeout_o",  timeout_o,  e.tmo);
            chk(e.tag, e.idx, "err_o",      err_o,      e.err);
         end
      end

      @(negedge clk_i);
      isolate_req_i = '0; aw_hs_i = '0; ar_hs_i = '0; b_hs_i = '0; r_last_hs_i = '0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/secure_subsystem_isolate_ctrl.md
SECURE_SUBSYSTEM_ISOLATE_CTRL -- requirements
Module: secure_subsystem_isolate_ctrl

Interface
REQ-001 SHALL have parameter NumPorts, default 2: number of independently isolated AXI ports.
REQ-002 SHALL have parameter MaxPending, default 8: maximum outstanding transactions per direction per port.
REQ-003 SHALL have parameter TimeoutCycles, default 1024: drain cycles before forced isolation; 0 disables the timeout.
REQ-004 SHALL have port clk_i  in  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port isolate_req_i  in  NumPorts  per-port isolation request, level.
REQ-007 SHALL have port aw_hs_i, ar_hs_i  in  NumPorts each  AW/AR valid&ready handshake pulses.
REQ-008 SHALL have port b_hs_i, r_last_hs_i  in  NumPorts each  B handshake / R handshake with last.
REQ-009 SHALL have port block_o  out  NumPorts  gate new AW/AR valids upstream.
REQ-010 SHALL have port isolated_o  out  NumPorts  port fully isolated.
REQ-011 SHALL have port timeout_o  out  NumPorts  sticky forced-isolation flag.
REQ-012 SHALL have port err_o  out  NumPorts  sticky protocol error (underflow, overflow, handshake while blocked).

Function
REQ-013 SHALL keep per port a write counter (+1 on aw_hs, -1 on b_hs) and a read counter (+1 on ar_hs, -1 on r_last_hs), each $clog2(MaxPending+1) bits.
REQ-014 SHALL leave a counter unchanged when its increment and decrement occur in the same cycle.
REQ-015 SHALL hold a counter at 0 on decrement-at-0 and hold it at MaxPending on increment-at-MaxPending, setting err_o in both cases.
REQ-016 SHALL run a per-port FSM with states RUN, DRAIN, ISOLATED, FORCED.
REQ-017 SHALL, in RUN, assert block_o only when either counter equals MaxPending (flow control).
REQ-018 SHALL move RUN->DRAIN when isolate_req_i is sampled high.
REQ-019 SHALL drive block_o=1 from the cycle after the request is sampled; block_o is a registered function of state and counters only.
REQ-020 SHALL count handshakes in the request cycle normally.
REQ-021 SHALL, in DRAIN, ISOLATED and FORCED, count any aw_hs/ar_hs and set err_o.
REQ-022 SHALL, in DRAIN, increment a timeout counter each cycle.
REQ-023 SHALL move DRAIN->ISOLATED when both counters are 0, taking priority over timeout expiry in the same cycle.
REQ-024 SHALL move DRAIN->FORCED when the timeout counter reaches TimeoutCycles-1 with counters non-zero.
REQ-025 SHALL move DRAIN->RUN, clearing the timeout counter, if isolate_req_i deasserts.
REQ-026 SHALL assert isolated_o=1 in ISOLATED and FORCED, registered, one cycle after state entry.
REQ-027 SHALL set timeout_o on FORCED entry.
REQ-028 SHALL exit ISOLATED->RUN when isolate_req_i is low.
REQ-029 SHALL exit FORCED->RUN when isolate_req_i is low, clearing both counters that cycle.
REQ-030 SHALL clear timeout_o and err_o only by reset.
REQ-031 SHALL operate all ports fully independently; simultaneous events on different ports do not interact.

Reset
REQ-032 SHALL, while rst_i=1 at a clock edge, clear all counters and go to RUN.
REQ-033 SHALL, on reset, drive block_o=0, isolated_o=0, timeout_o=0, err_o=0 from the next cycle.
REQ-034 SHALL, on reset mid-DRAIN or mid-FORCED, abandon state with no residual flags.

Structure
REQ-035 SHALL place the state enum iso_state_e and counter-width helper in a shared package secure_subsystem_isolate_pkg.
REQ-036 SHALL implement one port in sub-module secure_subsystem_isolate_port, instantiated NumPorts times in a generate loop.

Verification (NumPorts=2, MaxPending=4, TimeoutCycles=16)
REQ-037 SHALL cover clean drain: port0 3 AW, req high, 3 B over 5 cycles -> block_o[0]=1 next cycle, isolated_o[0]=1 one cycle after last B, timeout_o=0.
REQ-038 SHALL cover timeout: port1 1 AR, req high, no R -> FORCED at drain cycle 16, timeout_o[1]=isolated_o[1]=1; req low -> RUN, counters 0.
REQ-039 SHALL cover flow control: 4 AW without B -> block_o=1; one B -> block_o=0 next cycle; a 5th AW while full -> err_o=1, counter stays 4.
REQ-040 SHALL cover simultaneous events: aw_hs and b_hs in the same cycle at count 2 -> count 2; b_hs at count 0 -> err_o=1, count 0.
REQ-041 SHALL cover independence and abort: port0 isolated while port1 traffic flows unaffected; req dropped mid-DRAIN -> RUN, no timeout_o.
REQ-042 SHALL cover reset: rst_i pulsed in FORCED -> all outputs 0 next cycle, RUN.
